wb_arbiter: RTL and testbench

//  Single register-file write-port arbiter at the tail of the execute stages.

---
 rtl/params_pkg.sv | 18 +
 rtl/wb_skid_fifo.sv | 120 ++++++++++++
 rtl/wb_arbiter.sv | 124 ++++++++++++
 tb/tb_wb_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/params_pkg.sv
// Shared widths and the write-back entry type for the execute/write-back stages.
package params_pkg;

    localparam int REGISTER_WIDTH = 5;
    localparam int DATA_WIDTH     = 32;

    typedef struct packed {
        logic                      valid;
        logic [REGISTER_WIDTH-1:0] wr_reg;
        logic [DATA_WIDTH-1:0]     data;
    } wb_entry_t;

    // A live entry aimed at r0 still occupies its slot but never reaches the register file.
    function automatic logic entry_writes(input wb_entry_t e);
        return e.valid && (e.wr_reg != {REGISTER_WIDTH{1'b0}});
    endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// In-order circular skid buffer for ALU results, with per-entry WAW squash compare.
// Optional bypass search (youngest valid match) is built when WB_BYPASS_EN is defined.
import params_pkg::*;

module wb_skid_fifo #(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push_i,
    input  wb_entry_t                 push_entry_i,
    input  logic                      pop_i,
    input  logic                      squash_i,
    input  logic [REGISTER_WIDTH-1:0] squash_reg_i,
    output wb_entry_t                 head_o,
    output logic [CNT_W-1:0]          count_o
`ifdef WB_BYPASS_EN
    ,
    input  logic [REGISTER_WIDTH-1:0] byp_reg_i,
    output logic                      byp_hit_o,
    output logic [DATA_WIDTH-1:0]     byp_data_o
`endif
);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] squash_vec_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign pop_ok_s  = pop_i && (count_q != {CNT_W{1'b0}});
    assign push_ok_s = push_i && (count_q != CNT_W'(DEPTH));
    assign head_o    = mem_q[head_q];
    assign count_o   = count_q;

    // Stale (already popped) slots have valid cleared, so they never match.
    always_comb begin
        squash_vec_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            squash_vec_s[i] = squash_i && mem_q[i].valid && (mem_q[i].wr_reg == squash_reg_i);
        end
    end

    // Next state: squash first so a same-cycle push at the tail survives.
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (squash_vec_s[i]) begin
                mem_d[i].valid = 1'b0;
            end else begin
                mem_d[i] = mem_d[i];
            end
        end
        if (pop_ok_s) begin
            mem_d[head_q].valid = 1'b0;
            head_d              = ptr_inc(head_q);
        end else begin
            head_d = head_q;
        end
        if (push_ok_s) begin
            mem_d[tail_q] = push_entry_i;
            tail_d        = ptr_inc(tail_q);
        end else begin
            tail_d = tail_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifdef WB_BYPASS_EN
    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        byp_hit_o  = 1'b0;
        byp_data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            automatic int idx = (int'(head_q) + k) % DEPTH;
            if ((CNT_W'(k) < count_q) && mem_q[idx].valid &&
                (mem_q[idx].wr_reg == byp_reg_i) &&
                (byp_reg_i != {REGISTER_WIDTH{1'b0}})) begin
                byp_hit_o  = 1'b1;
                byp_data_o = mem_q[idx].data;
            end else begin
                byp_hit_o  = byp_hit_o;
            end
        end
    end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: mul (non-stallable) beats buffered ALU beats direct ALU.
// Optional bypass lookup into the skid buffer is enabled by defining WB_BYPASS_EN.
import params_pkg::*;

module wb_arbiter #(
    parameter  int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
    parameter  int DATA_WIDTH     = params_pkg::DATA_WIDTH,
    parameter  int DEPTH          = 2,
    localparam int CNT_W          = $clog2(DEPTH + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      mul_valid_i,
    input  logic [REGISTER_WIDTH-1:0] mul_wr_reg_i,
    input  logic [DATA_WIDTH-1:0]     mul_result_i,
    input  logic                      alu_valid_i,
    output logic                      alu_ready_o,
    input  logic [REGISTER_WIDTH-1:0] alu_wr_reg_i,
    input  logic [DATA_WIDTH-1:0]     alu_result_i,
    output logic                      rf_wr_en_o,
    output logic [REGISTER_WIDTH-1:0] rf_wr_reg_o,
    output logic [DATA_WIDTH-1:0]     rf_wr_data_o,
    output logic [CNT_W-1:0]          buf_count_o
`ifdef WB_BYPASS_EN
    ,
    input  logic [REGISTER_WIDTH-1:0] byp_reg_i,
    output logic                      byp_hit_o,
    output logic [DATA_WIDTH-1:0]     byp_data_o
`endif
);

    wb_entry_t                 head_s;
    wb_entry_t                 win_s;
    wb_entry_t                 alu_entry_s;
    logic [CNT_W-1:0]          count_s;
    logic                      alu_fire_s;
    logic                      push_s;
    logic                      pop_s;
    logic                      wr_en_d, wr_en_q;
    logic [REGISTER_WIDTH-1:0] wr_reg_d, wr_reg_q;
    logic [DATA_WIDTH-1:0]     wr_data_d, wr_data_q;

    assign alu_ready_o = (count_s != CNT_W'(DEPTH));
    assign alu_fire_s  = alu_valid_i && alu_ready_o;
    assign alu_entry_s = '{valid: 1'b1, wr_reg: alu_wr_reg_i, data: alu_result_i};

    wb_skid_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (push_s),
        .push_entry_i (alu_entry_s),
        .pop_i        (pop_s),
        .squash_i     (mul_valid_i),
        .squash_reg_i (mul_wr_reg_i),
        .head_o       (head_s),
        .count_o      (count_s)
`ifdef WB_BYPASS_EN
        ,
        .byp_reg_i    (byp_reg_i),
        .byp_hit_o    (byp_hit_o),
        .byp_data_o   (byp_data_o)
`endif
    );

    // Winner selection. A squashed last entry lets a same-cycle ALU result go
    // straight to the register file; with older entries behind it the ALU must queue.
    always_comb begin
        win_s  = '0;
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (mul_valid_i) begin
            win_s  = '{valid: 1'b1, wr_reg: mul_wr_reg_i, data: mul_result_i};
            push_s = alu_fire_s;
        end else if (count_s != {CNT_W{1'b0}}) begin
            pop_s = 1'b1;
            if (head_s.valid) begin
                win_s  = head_s;
                push_s = alu_fire_s;
            end else if (alu_fire_s && (count_s == CNT_W'(1))) begin
                win_s  = alu_entry_s;
                push_s = 1'b0;
            end else begin
                push_s = alu_fire_s;
            end
        end else if (alu_fire_s) begin
            win_s = alu_entry_s;
        end else begin
            win_s = '0;
        end
    end

    // Index/data only move on a real write.
    always_comb begin
        wr_en_d = entry_writes(win_s);
        if (wr_en_d) begin
            wr_reg_d  = win_s.wr_reg;
            wr_data_d = win_s.data;
        end else begin
            wr_reg_d  = wr_reg_q;
            wr_data_d = wr_data_q;
        end
    end

    // Registered write port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign rf_wr_en_o   = wr_en_q;
    assign rf_wr_reg_o  = wr_reg_q;
    assign rf_wr_data_o = wr_data_q;
    assign buf_count_o  = count_s;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
    import params_pkg::*;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      mul_valid = 1'b0;
    logic [REGISTER_WIDTH-1:0] mul_reg = '0;
    logic [DATA_WIDTH-1:0]     mul_res = '0;
    logic                      alu_valid = 1'b0;
    logic                      alu_ready;
    logic [REGISTER_WIDTH-1:0] alu_reg = '0;
    logic [DATA_WIDTH-1:0]     alu_res = '0;
    logic                      rf_en;
    logic [REGISTER_WIDTH-1:0] rf_reg;
    logic [DATA_WIDTH-1:0]     rf_data;
    logic [CNT_W-1:0]          buf_count;
`ifdef WB_BYPASS_EN
    logic [REGISTER_WIDTH-1:0] byp_reg = '0;
    logic                      byp_hit;
    logic [DATA_WIDTH-1:0]     byp_data;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .mul_valid_i  (mul_valid),
        .mul_wr_reg_i (mul_reg),
        .mul_result_i (mul_res),
        .alu_valid_i  (alu_valid),
        .alu_ready_o  (alu_ready),
        .alu_wr_reg_i (alu_reg),
        .alu_result_i (alu_res),
        .rf_wr_en_o   (rf_en),
        .rf_wr_reg_o  (rf_reg),
        .rf_wr_data_o (rf_data),
        .buf_count_o  (buf_count)
`ifdef WB_BYPASS_EN
        ,
        .byp_reg_i    (byp_reg),
        .byp_hit_o    (byp_hit),
        .byp_data_o   (byp_data)
`endif
    );

    // Reference model: the skid buffer is an ordered list of pending ALU results.
    typedef struct {
        bit                        live;
        logic [REGISTER_WIDTH-1:0] r;
        logic [DATA_WIDTH-1:0]     d;
    } ment_t;

    ment_t                     mq[$];
    bit                        exp_en = 1'b0;
    logic [REGISTER_WIDTH-1:0] exp_reg = '0;
    logic [DATA_WIDTH-1:0]     exp_data = '0;
    bit                        last_fire = 1'b0;

    // Apply the arbitration rules to the current inputs, then advance one clock.
    task automatic tick();
        bit                        fire, win, taken;
        logic [REGISTER_WIDTH-1:0] wr;
        logic [DATA_WIDTH-1:0]     wd;
        ment_t                     h, e;
        fire = 1'b0; win = 1'b0; taken = 1'b0; wr = '0; wd = '0;
        if (rst) begin
            mq.delete();
            exp_en = 1'b0; exp_reg = '0; exp_data = '0;
        end else begin
            fire = alu_valid && (mq.size() != DEPTH);
            if (mul_valid) begin
                foreach (mq[i]) if (mq[i].r == mul_reg) mq[i].live = 1'b0;
                win = 1'b1; wr = mul_reg; wd = mul_res;
            end else if (mq.size() > 0) begin
                h = mq.pop_front();
                if (h.live) begin
                    win = 1'b1; wr = h.r; wd = h.d;
                end else if (fire && mq.size() == 0) begin
                    win = 1'b1; wr = alu_reg; wd = alu_res; taken = 1'b1;
                end
            end else if (fire) begin
                win = 1'b1; wr = alu_reg; wd = alu_res; taken = 1'b1;
            end
            if (fire && !taken) begin
                e.live = 1'b1; e.r = alu_reg; e.d = alu_res;
                mq.push_back(e);
            end
            exp_en = win && (wr != '0);
            if (exp_en) begin
                exp_reg = wr; exp_data = wd;
            end
        end
        last_fire = fire;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mul_valid = 1'b0; alu_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) tick();
        rst = 1'b0;
        checks += 5;
        if (rf_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b want=0", rf_en); end
        if (buf_count !== '0) begin failures++; $display("FAIL reset_count got=%0d want=0", buf_count); end
        if (alu_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", alu_ready); end
        if (rf_reg !== '0) begin failures++; $display("FAIL reset_reg got=%0d want=0", rf_reg); end
        if (rf_data !== '0) begin failures++; $display("FAIL reset_data got=%h want=0", rf_data); end
    endtask

    task automatic test_alu_only();
        alu_valid = 1'b1; alu_reg = 5'd5; alu_res = 32'h11;
        tick();
        idle_inputs();
        checks += 4;
        if (rf_en !== 1'b1) begin failures++; $display("FAIL alu_only_en got=%b want=1", rf_en); end
        if (rf_reg !== 5'd5) begin failures++; $display("FAIL alu_only_reg got=%0d want=5", rf_reg); end
        if (rf_data !== 32'h11) begin failures++; $display("FAIL alu_only_data got=%h want=11", rf_data); end
        if (buf_count !== 2'd0) begin failures++; $display("FAIL alu_only_count got=%0d want=0", buf_count); end
    endtask

    task automatic test_mul_alu();
        mul_valid = 1'b1; mul_reg = 5'd3; mul_res = 32'h20;
        alu_valid = 1'b1; alu_reg = 5'd4; alu_res = 32'h30;
        tick();
        idle_inputs();
        checks += 4;
        if (rf_en !== 1'b1) begin failures++; $display("FAIL mul_alu_en1 got=%b want=1", rf_en); end
        if (rf_reg !== 5'd3 || rf_data !== 32'h20) begin
            failures++; $display("FAIL mul_alu_w1 got=r%0d/%h want=r3/20", rf_reg, rf_data);
        end
        if (buf_count !== 2'd1) begin failures++; $display("FAIL mul_alu_count1 got=%0d want=1", buf_count); end
        tick();
        if (rf_en !== 1'b1 || rf_reg !== 5'd4 || rf_data !== 32'h30 || buf_count !== 2'd0) begin
            failures++;
            $display("FAIL mul_alu_w2 got=en%b r%0d/%h cnt%0d want=en1 r4/30 cnt0", rf_en, rf_reg, rf_data, buf_count);
        end
    endtask

    task automatic test_back_to_back();
        int ready_low = 0;
        int nxt = 20;
        alu_valid = 1'b1; alu_reg = 5'(nxt); alu_res = 32'h100 + 32'(nxt);
        for (int c = 0; c < 9; c++) begin
            mul_valid = (c < 4);
            mul_reg = 5'(10 + c); mul_res = 32'h900 + 32'(c);
            checks++;
            if (alu_ready !== (mq.size() != DEPTH)) begin
                failures++; $display("FAIL b2b_ready c=%0d got=%b want=%b", c, alu_ready, mq.size() != DEPTH);
            end
            if (alu_ready === 1'b0) ready_low++;
            tick();
            checks++;
            if (rf_en !== exp_en || rf_reg !== exp_reg || rf_data !== exp_data || buf_count !== CNT_W'(mq.size())) begin
                failures++;
                $display("FAIL b2b_out c=%0d got=en%b r%0d/%h cnt%0d want=en%b r%0d/%h cnt%0d",
                         c, rf_en, rf_reg, rf_data, buf_count, exp_en, exp_reg, exp_data, mq.size());
            end
            if (last_fire) begin
                nxt++;
                alu_reg = 5'(nxt); alu_res = 32'h100 + 32'(nxt);
                if (nxt > 22) alu_valid = 1'b0;
            end
        end
        idle_inputs();
        checks++;
        if (ready_low != 3) begin failures++; $display("FAIL b2b_ready_low got=%0d want=3", ready_low); end
    endtask

    task automatic test_waw();
        mul_valid = 1'b1; mul_reg = 5'd1; mul_res = 32'h1;
        alu_valid = 1'b1; alu_reg = 5'd7; alu_res = 32'hAA;
        tick();
        alu_valid = 1'b0; mul_reg = 5'd7; mul_res = 32'hBB;
        tick();
        mul_valid = 1'b0;
        checks += 2;
        if (rf_en !== 1'b1 || rf_reg !== 5'd7 || rf_data !== 32'hBB || buf_count !== 2'd1) begin
            failures++;
            $display("FAIL waw_mul got=en%b r%0d/%h cnt%0d want=en1 r7/bb cnt1", rf_en, rf_reg, rf_data, buf_count);
        end
        tick();
        if (rf_en !== 1'b0 || rf_reg !== 5'd7 || rf_data !== 32'hBB || buf_count !== 2'd0) begin
            failures++;
            $display("FAIL waw_squash_pop got=en%b r%0d/%h cnt%0d want=en0 r7/bb cnt0", rf_en, rf_reg, rf_data, buf_count);
        end
    endtask

    task automatic test_reg0();
        alu_valid = 1'b1; alu_reg = 5'd0; alu_res = 32'h5;
        tick();
        idle_inputs();
        checks++;
        if (rf_en !== 1'b0 || rf_data !== 32'hBB || buf_count !== 2'd0) begin
            failures++; $display("FAIL reg0 got=en%b data%h cnt%0d want=en0 databb cnt0", rf_en, rf_data, buf_count);
        end
    endtask

    task automatic test_bypass();
`ifdef WB_BYPASS_EN
        mul_valid = 1'b1; mul_reg = 5'd1; mul_res = 32'h0;
        alu_valid = 1'b1; alu_reg = 5'd9; alu_res = 32'h1;
        tick();
        mul_reg = 5'd2; alu_res = 32'h2;
        tick();
        idle_inputs();
        byp_reg = 5'd9;
        #1;
        checks += 2;
        if (byp_hit !== 1'b1 || byp_data !== 32'h2) begin
            failures++; $display("FAIL bypass_hit got=%b/%h want=1/2", byp_hit, byp_data);
        end
        byp_reg = 5'd0;
        #1;
        if (byp_hit !== 1'b0 || byp_data !== 32'h0) begin
            failures++; $display("FAIL bypass_r0 got=%b/%h want=0/0", byp_hit, byp_data);
        end
        repeat (3) tick();
`endif
    endtask

    task automatic test_reset_mid();
        mul_valid = 1'b1; mul_reg = 5'd6; mul_res = 32'h66;
        alu_valid = 1'b1; alu_reg = 5'd8; alu_res = 32'h88;
        repeat (2) tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (rf_en !== 1'b0 || rf_reg !== '0 || rf_data !== '0 || buf_count !== '0 || alu_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid got=en%b r%0d/%h cnt%0d rdy%b want=en0 r0/0 cnt0 rdy1",
                     rf_en, rf_reg, rf_data, buf_count, alu_ready);
        end
        tick();
        checks++;
        if (rf_en !== 1'b0 || buf_count !== '0) begin
            failures++; $display("FAIL reset_mid_drain got=en%b cnt%0d want=en0 cnt0", rf_en, buf_count);
        end
    endtask

    task automatic test_random();
`ifdef WB_BYPASS_EN
        bit                    eh;
        logic [DATA_WIDTH-1:0] ed;
`endif
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            mul_valid = ($urandom_range(0, 9) < 4);
            mul_reg = 5'($urandom_range(0, 7));
            mul_res = $urandom;
            if (!alu_valid || last_fire) begin
                alu_valid = ($urandom_range(0, 9) < 7);
                alu_reg = 5'($urandom_range(0, 7));
                alu_res = $urandom;
            end
`ifdef WB_BYPASS_EN
            byp_reg = 5'($urandom_range(0, 7));
            #1;
            eh = 1'b0; ed = '0;
            foreach (mq[i]) if (mq[i].live && mq[i].r == byp_reg && byp_reg != '0) begin eh = 1'b1; ed = mq[i].d; end
            checks++;
            if (byp_hit !== eh || byp_data !== ed) begin
                failures++; $display("FAIL rand_bypass c=%0d got=%b/%h want=%b/%h", c, byp_hit, byp_data, eh, ed);
            end
`endif
            checks++;
            if (alu_ready !== (mq.size() != DEPTH)) begin
                failures++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, alu_ready, mq.size() != DEPTH);
            end
            tick();
            checks++;
            if (rf_en !== exp_en || rf_reg !== exp_reg || rf_data !== exp_data || buf_count !== CNT_W'(mq.size())) begin
                failures++;
                $display("FAIL rand_out c=%0d got=en%b r%0d/%h cnt%0d want=en%b r%0d/%h cnt%0d",
                         c, rf_en, rf_reg, rf_data, buf_count, exp_en, exp_reg, exp_data, mq.size());
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        #1;
        test_reset();
        test_alu_only();
        test_mul_alu();
        test_back_to_back();
        test_waw();
        test_reg0();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
